// File: rtl/receiver_pkg.sv
// receiver_pkg: shared constants and types for the UART receive stage.
//   - data width codes (DW_*), stop bit code (SB_2BIT), line idle level
//   - parity mode bit positions, default parameter values
//   - receiver_fsm_e: deframing FSM state encoding
//   - last_bit_idx(): index of the final data bit for a width code
package receiver_pkg;

    localparam logic [1:0] DW_5BIT = 2'b00;
    localparam logic [1:0] DW_6BIT = 2'b01;
    localparam logic [1:0] DW_7BIT = 2'b10;
    localparam logic [1:0] DW_8BIT = 2'b11;

    localparam logic [1:0] SB_2BIT = 2'b01;

    localparam logic RX_LINE_IDLE = 1'b1;

    // parity_mode_i bit meanings
    localparam int PARITY_DIS_BIT = 1;
    localparam int PARITY_ODD_BIT = 0;

    localparam int RX_FIFO_DEPTH_DEF  = 16;
    localparam int CFG_REQ_CYCLES_DEF = 100000;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_CFG_WAIT
    } receiver_fsm_e;

    function automatic logic [2:0] last_bit_idx(input logic [1:0] dw);
        logic [2:0] idx;
        case (dw)
            DW_5BIT: idx = 3'd4;
            DW_6BIT: idx = 3'd5;
            DW_7BIT: idx = 3'd6;
            DW_8BIT: idx = 3'd7;
            default: idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/receiver_fifo.sv
// sync_FIFO_buffer: first-word-fall-through synchronous FIFO for received
// bytes. Present only when UART_RX_FIFO_EN is defined; the default build
// uses a single holding register inside receiver instead.
//   clk_i, rst_n_i   clock, asynchronous active-low reset (clears pointers)
//   wr_en_i/wr_data_i  push (caller guarantees not full unless popping)
//   rd_en_i          pop (caller guarantees not empty)
//   rd_data_o        head entry, 0 while empty
//   empty_o, full_o  status
`ifdef UART_RX_FIFO_EN
module sync_FIFO_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    // extra pointer MSB distinguishes full from empty
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule
`endif

// File: rtl/receiver.sv
// receiver: UART receive stage. Oversamples rx_i with the 16x baud tick,
// deframes start/data/parity/stop bits, buffers bytes with per-frame error
// pulses, and flags a peer configuration request (line low CFG_REQ_CYCLES).
// Build option: UART_RX_FIFO_EN selects a RX_FIFO_DEPTH FWFT FIFO;
// otherwise a single holding register (full = !empty).
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   enable                    allow new frames to start
//   ov_baud_rt_i              16x baud tick
//   rx_i                      serial line, asynchronous, idle high
//   data_width_i, stop_bits_number_i, parity_mode_i   frame format
//   rx_fifo_read_i            pop head byte
//   data_rx_o, rx_fifo_empty_o, rx_fifo_full_o        buffer head/status
//   rx_done_o, parity_error_o, frame_error_o, overrun_error_o  frame pulses
//   config_req_slv_o          configuration request pulse
//
// state       | meaning
// RX_IDLE     | waiting for falling edge with enable=1
// RX_START    | confirm start bit at mid-bit (tick 7)
// RX_DATA     | sample data bits every 16 ticks
// RX_PARITY   | sample and check parity bit
// RX_STOP     | sample one or two stop bits, then push
// RX_CFG_WAIT | config request seen, wait for line high
module receiver
    import receiver_pkg::*;
#(
    parameter int CFG_REQ_CYCLES = CFG_REQ_CYCLES_DEF,
    parameter int RX_FIFO_DEPTH  = RX_FIFO_DEPTH_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable,
    input  logic       ov_baud_rt_i,
    input  logic       rx_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] stop_bits_number_i,
    input  logic [1:0] parity_mode_i,
    input  logic       rx_fifo_read_i,
    output logic [7:0] data_rx_o,
    output logic       rx_fifo_empty_o,
    output logic       rx_fifo_full_o,
    output logic       rx_done_o,
    output logic       parity_error_o,
    output logic       frame_error_o,
    output logic       overrun_error_o,
    output logic       config_req_slv_o
);
    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RX_FIFO_DEPTH must be a power of two, at least 2");
    end
    if (CFG_REQ_CYCLES < 2) begin : g_bad_cfg
        $error("CFG_REQ_CYCLES must be at least 2");
    end

    localparam int LCW = $clog2(CFG_REQ_CYCLES + 1);
    localparam logic [LCW-1:0] LOW_HIT = LCW'(CFG_REQ_CYCLES - 1);
    localparam logic [LCW-1:0] LOW_SAT = LCW'(CFG_REQ_CYCLES);

    logic           rx_meta_q, rx_sync_q, rx_prev_q;
    receiver_fsm_e  state_q, state_d;
    logic [3:0]     tick_cnt_q, tick_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           stop_cnt_q, stop_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_err_q, par_err_d;
    logic           frm_err_q, frm_err_d;
    logic [LCW-1:0] low_cnt_q;
    logic           push, cfg_hit, fall, mid_bit;
    logic           rx_done_q, par_pulse_q, frm_pulse_q, ovr_pulse_q, cfg_pulse_q;
    logic           full, empty, pop;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta_q <= RX_LINE_IDLE;
            rx_sync_q <= RX_LINE_IDLE;
            rx_prev_q <= RX_LINE_IDLE;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign fall = rx_prev_q & ~rx_sync_q;

    // Saturates one past the hit value so a single low run fires once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                low_cnt_q <= '0;
        else if (rx_sync_q)          low_cnt_q <= '0;
        else if (low_cnt_q != LOW_SAT) low_cnt_q <= low_cnt_q + LCW'(1);
    end

    assign cfg_hit = ~rx_sync_q && (low_cnt_q == LOW_HIT);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        push       = 1'b0;
        mid_bit    = ov_baud_rt_i && (tick_cnt_q == 4'd15);
        // 4-bit tick counter wraps 15 -> 0, restarting each bit period
        if (ov_baud_rt_i && state_q inside {RX_DATA, RX_PARITY, RX_STOP})
            tick_cnt_d = tick_cnt_q + 4'd1;
        case (state_q)
            RX_IDLE: begin
                if (enable && fall) begin
                    state_d    = RX_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    shift_d    = '0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            RX_START: begin
                if (ov_baud_rt_i) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        state_d    = rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (mid_bit) begin
                    shift_d[bit_cnt_q] = rx_sync_q;
                    if (bit_cnt_q == last_bit_idx(data_width_i)) begin
                        bit_cnt_d = '0;
                        state_d   = parity_mode_i[PARITY_DIS_BIT] ? RX_STOP : RX_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (mid_bit) begin
                    par_err_d = ((^shift_q) ^ rx_sync_q) != parity_mode_i[PARITY_ODD_BIT];
                    state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (mid_bit) begin
                    frm_err_d = frm_err_q | ~rx_sync_q;
                    if (stop_bits_number_i == SB_2BIT && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_CFG_WAIT: begin
                if (rx_sync_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
        // a configuration request aborts whatever frame is in flight
        if (cfg_hit) begin
            state_d = RX_CFG_WAIT;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= RX_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign pop = rx_fifo_read_i & ~empty;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_done_q   <= 1'b0;
            par_pulse_q <= 1'b0;
            frm_pulse_q <= 1'b0;
            ovr_pulse_q <= 1'b0;
            cfg_pulse_q <= 1'b0;
        end else begin
            rx_done_q   <= push;
            par_pulse_q <= push & par_err_q;
            frm_pulse_q <= push & frm_err_d;
            ovr_pulse_q <= push & full & ~pop;
            cfg_pulse_q <= cfg_hit;
        end
    end

`ifdef UART_RX_FIFO_EN
    sync_FIFO_buffer #(
        .WIDTH (8),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (push & (~full | pop)),
        .wr_data_i (shift_q),
        .rd_en_i   (pop),
        .rd_data_o (data_rx_o),
        .empty_o   (empty),
        .full_o    (full)
    );
`else
    logic [7:0] hold_q;
    logic       valid_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else if (push && (!valid_q || pop)) begin
            hold_q  <= shift_q;
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign empty     = ~valid_q;
    assign full      = valid_q;
    assign data_rx_o = valid_q ? hold_q : 8'h00;
`endif

    assign rx_fifo_empty_o  = empty;
    assign rx_fifo_full_o   = full;
    assign rx_done_o        = rx_done_q;
    assign parity_error_o   = par_pulse_q;
    assign frame_error_o    = frm_pulse_q;
    assign overrun_error_o  = ovr_pulse_q;
    assign config_req_slv_o = cfg_pulse_q;

endmodule
